// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional skid entry, flush and NOP-gated control
//
// Parameters:
//   DATA_W  payload width (>= 1)
//   CTRL_W  control bundle width (>= 1)
//   SKID    1 = skid entry present, in_ready registered; 0 = single entry, in_ready combinational
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous kill of every held entry
//   in_valid/in_ready     upstream handshake, in_data/in_ctrl upstream entry
//   out_valid/out_ready   downstream handshake, out_data/out_ctrl main register contents
//   level                 number of held entries (0..2)

module pipe_stage_reg #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        level
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic              main_valid;
    logic              skid_valid;
    logic              accept;
    logic              drain;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    assign main_valid = (state_q != ST_EMPTY);
    assign skid_valid = (state_q == ST_SKID);
    assign accept     = in_valid & in_ready;
    assign drain      = main_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            // Loads are suppressed too so out_data keeps its last delivered value.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d      = ST_FULL;
                        load_main_in = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (drain && accept) begin
                        load_main_in = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end else if (accept && (SKID != 0)) begin
                        // Entry accepted while in_ready was still high from last cycle.
                        state_d   = ST_SKID;
                        load_skid = 1'b1;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        state_d        = ST_FULL;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else if (load_main_in) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
        end else if (load_main_skid) begin
            main_data_q <= skid_data;
            main_ctrl_q <= skid_ctrl;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic              in_ready_q;
            logic [DATA_W-1:0] skid_data_q;
            logic [CTRL_W-1:0] skid_ctrl_q;

            // Registered so out_ready never reaches in_ready combinationally.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != ST_SKID);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skid_data_q <= '0;
                    skid_ctrl_q <= '0;
                end else if (load_skid) begin
                    skid_data_q <= in_data;
                    skid_ctrl_q <= in_ctrl;
                end
            end

            assign in_ready  = in_ready_q;
            assign skid_data = skid_data_q;
            assign skid_ctrl = skid_ctrl_q;
        end else begin : g_noskid
            assign in_ready  = ~main_valid | out_ready;
            assign skid_data = '0;
            assign skid_ctrl = '0;
        end
    endgenerate

    assign out_valid = main_valid;
    assign out_data  = main_data_q;
    // An empty slot must look like a NOP to the next stage.
    assign out_ctrl  = main_valid ? main_ctrl_q : '0;
    assign level     = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg, SKID=1 and SKID=0 instances

module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;

    logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [1:0]    a_level;

    logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [1:0]    b_level;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [CW+DW-1:0] a_q[$];
    logic [CW+DW-1:0] b_q[$];

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .level(a_level)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .level(b_level)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic a_drive(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic expect_out);
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_ctrl  = c;
        if (expect_out) a_q.push_back({c, d});
    endtask

    task automatic b_drive(input logic [DW-1:0] d, input logic [CW-1:0] c);
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_ctrl  = c;
        b_q.push_back({c, d});
    endtask

    // Monitors: pop the next expected entry on every downstream transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!a_out_valid) chk("a_nop_ctrl", 64'(a_out_ctrl), 64'd0);
            if (a_out_valid && a_out_ready && !a_flush) begin
                if (a_q.size() == 0) begin
                    chk("a_unexpected_out", 64'({a_out_ctrl, a_out_data}), 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    chk("a_order", 64'({a_out_ctrl, a_out_data}), 64'(a_q.pop_front()));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (!b_out_valid) chk("b_nop_ctrl", 64'(b_out_ctrl), 64'd0);
            if (b_out_valid && b_out_ready && !b_flush) begin
                if (b_q.size() == 0) begin
                    chk("b_unexpected_out", 64'({b_out_ctrl, b_out_data}), 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    chk("b_order", 64'({b_out_ctrl, b_out_data}), 64'(b_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        a_flush     = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'hA5;
        a_in_ctrl   = 16'hFFFF;
        a_out_ready = 1'b1;
        b_flush     = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_in_ctrl   = '0;
        b_out_ready = 1'b1;

        // Reset with a valid entry presented: nothing may be taken.
        repeat (3) tick();
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_ctrl",  64'(a_out_ctrl),  64'd0);
        chk("rst_out_data",  64'(a_out_data),  64'd0);
        chk("rst_level",     64'(a_level),     64'd0);
        chk("rst_in_ready",  64'(a_in_ready),  64'd1);
        chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        chk("rst_b_level",   64'(b_level),     64'd0);

        rst_n = 1'b1;
        a_q.push_back({16'hFFFF, 32'hA5});
        tick();
        chk("post_rst_valid", 64'(a_out_valid), 64'd1);
        chk("post_rst_ctrl",  64'(a_out_ctrl),  64'hFFFF);
        a_in_valid = 1'b0;
        tick();
        chk("post_rst_drained", 64'(a_out_valid), 64'd0);

        // Streaming 1..8 at full rate.
        for (int i = 1; i <= 8; i++) begin
            a_drive(DW'(i), CW'(16'h100 + i), 1'b1);
            tick();
            chk("stream_valid",    64'(a_out_valid), 64'd1);
            chk("stream_data",     64'(a_out_data),  64'(i));
            chk("stream_in_ready", 64'(a_in_ready),  64'd1);
        end
        a_in_valid = 1'b0;
        tick();
        chk("stream_empty", 64'(a_level), 64'd0);

        // Backpressure: A on output, then out_ready drops.
        a_drive(32'h0A, 16'h1A, 1'b1);
        tick();
        chk("bp_a_out", 64'(a_out_data), 64'h0A);
        a_drive(32'h0B, 16'h1B, 1'b1);
        a_out_ready = 1'b0;
        tick();
        chk("bp_level2",   64'(a_level),    64'd2);
        chk("bp_in_ready", 64'(a_in_ready), 64'd0);
        chk("bp_hold_a",   64'(a_out_data), 64'h0A);
        a_drive(32'h0C, 16'h1C, 1'b1);
        tick();
        chk("bp_level2_hold", 64'(a_level),    64'd2);
        chk("bp_c_blocked",   64'(a_in_ready), 64'd0);
        a_out_ready = 1'b1;
        tick();
        chk("bp_b_out",     64'(a_out_data), 64'h0B);
        chk("bp_level1",    64'(a_level),    64'd1);
        chk("bp_ready_back", 64'(a_in_ready), 64'd1);
        tick();
        chk("bp_c_out", 64'(a_out_data), 64'h0C);
        a_in_valid = 1'b0;
        tick();
        chk("bp_empty", 64'(a_level), 64'd0);

        // Flush while in SKID state with a new entry on the input.
        a_out_ready = 1'b0;
        a_drive(32'h55, 16'h2F, 1'b0);
        tick();
        a_drive(32'h66, 16'h3F, 1'b0);
        tick();
        chk("fl_level2", 64'(a_level), 64'd2);
        a_drive(32'h77, 16'h4F, 1'b0);
        a_flush = 1'b1;
        tick();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        chk("fl_level0",   64'(a_level),     64'd0);
        chk("fl_valid0",   64'(a_out_valid), 64'd0);
        chk("fl_ctrl0",    64'(a_out_ctrl),  64'd0);
        chk("fl_in_ready", 64'(a_in_ready),  64'd1);
        a_out_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("fl_stays_empty", 64'(a_out_valid), 64'd0);
        end

        // Bubble of three cycles mid-stream.
        a_drive(32'h11, 16'h21, 1'b1);
        tick();
        chk("bub_d1", 64'(a_out_data), 64'h11);
        a_in_valid = 1'b0;
        repeat (3) begin
            tick();
            chk("bub_valid0", 64'(a_out_valid), 64'd0);
            chk("bub_ctrl0",  64'(a_out_ctrl),  64'd0);
            chk("bub_data_held", 64'(a_out_data), 64'h11);
        end
        a_drive(32'h12, 16'h22, 1'b1);
        tick();
        chk("bub_d2_valid", 64'(a_out_valid), 64'd1);
        chk("bub_d2_ctrl",  64'(a_out_ctrl),  64'h22);
        a_in_valid = 1'b0;
        tick();

        // SKID=0: combinational in_ready and single-cycle replacement.
        b_drive(32'hB0, 16'h30);
        tick();
        chk("b_p_out",   64'(b_out_data), 64'hB0);
        chk("b_ready_1", 64'(b_in_ready), 64'd1);
        b_out_ready = 1'b0;
        b_drive(32'hB1, 16'h31);
        #1;
        chk("b_ready_same_cycle", 64'(b_in_ready), 64'd0);
        tick();
        chk("b_hold_p",  64'(b_out_data), 64'hB0);
        chk("b_level1",  64'(b_level),    64'd1);
        chk("b_ready_0", 64'(b_in_ready), 64'd0);
        b_out_ready = 1'b1;
        #1;
        chk("b_ready_up", 64'(b_in_ready), 64'd1);
        tick();
        chk("b_q_out",   64'(b_out_data),  64'hB1);
        chk("b_q_valid", 64'(b_out_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            b_drive(DW'(32'hC0 + i), CW'(16'h40 + i));
            tick();
            chk("b_stream_data",  64'(b_out_data), 64'(32'hC0 + i));
            chk("b_stream_ready", 64'(b_in_ready), 64'd1);
        end
        b_in_valid = 1'b0;
        tick();
        chk("b_empty", 64'(b_level), 64'd0);

        repeat (2) tick();
        chk("a_all_delivered", 64'(a_q.size()), 64'd0);
        chk("b_all_delivered", 64'(b_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
